// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_types: shared pipeline control types for the hazard sequencer.
package pipe_types;
    typedef enum logic [0:0] {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID source that reads the destination of a load in EX (x0 never hazards).
module load_use_detect (
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_uses_rs1,
    input  logic       i_uses_rs2,
    input  logic [4:0] i_rd,
    input  logic       i_mem_read,
    output logic       o_hazard
);
    assign o_hazard = i_mem_read && (i_rd != 5'd0) &&
                      ((i_uses_rs1 && (i_rs1 == i_rd)) || (i_uses_rs2 && (i_rs2 == i_rd)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipe (cache miss freeze, load-use bubble, branch squash).
// Define HAZARD_PERF_EN to build the saturating stall/flush/load-use counters.
module pipeline_hazard_ctrl
    import pipe_types::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_imem_req,
    input  logic              i_imem_resp,
    input  logic              i_dmem_req,
    input  logic              i_dmem_resp,
    input  logic [4:0]        i_id_rs1,
    input  logic [4:0]        i_id_rs2,
    input  logic              i_id_uses_rs1,
    input  logic              i_id_uses_rs2,
    input  logic [4:0]        i_ex_rd,
    input  logic              i_ex_mem_read,
    input  logic              i_ex_br_taken,
    output logic              o_load_pc,
    output logic              o_load_if_id,
    output logic              o_load_id_ex,
    output logic              o_load_ex_mem,
    output logic              o_load_mem_wb,
    output logic              o_bubble_if_id,
    output logic              o_bubble_id_ex,
    output logic [PERF_W-1:0] o_stall_cycles,
    output logic [PERF_W-1:0] o_flush_count,
    output logic [PERF_W-1:0] o_load_use_count
);
    hz_state_t r_state;
    logic      r_i_done, r_d_done;
    logic      w_i_done, w_d_done, w_mem_pend, w_hazard, w_flush, w_load_use;

    load_use_detect u_lud (
        .i_rs1      (i_id_rs1),
        .i_rs2      (i_id_rs2),
        .i_uses_rs1 (i_id_uses_rs1),
        .i_uses_rs2 (i_id_uses_rs2),
        .i_rd       (i_ex_rd),
        .i_mem_read (i_ex_mem_read),
        .o_hazard   (w_hazard)
    );

    // Flags only carry meaning inside a miss; in RUN they are always clear.
    assign w_i_done   = (r_state == HZ_MEM_WAIT) && r_i_done;
    assign w_d_done   = (r_state == HZ_MEM_WAIT) && r_d_done;
    assign w_mem_pend = (i_imem_req && !i_imem_resp && !w_i_done) ||
                        (i_dmem_req && !i_dmem_resp && !w_d_done);
    assign w_flush    = !w_mem_pend && i_ex_br_taken;
    assign w_load_use = !w_mem_pend && !i_ex_br_taken && w_hazard;

    assign o_load_pc      = i_rst_n && !w_mem_pend && !w_load_use;
    assign o_load_if_id   = i_rst_n && !w_mem_pend && !w_load_use;
    assign o_load_id_ex   = i_rst_n && !w_mem_pend;
    assign o_load_ex_mem  = i_rst_n && !w_mem_pend;
    assign o_load_mem_wb  = i_rst_n && !w_mem_pend;
    assign o_bubble_if_id = i_rst_n && w_flush;
    assign o_bubble_id_ex = i_rst_n && (w_flush || w_load_use);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= HZ_RUN;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
        end else begin
            r_state  <= w_mem_pend ? HZ_MEM_WAIT : HZ_RUN;
            r_i_done <= w_mem_pend && (w_i_done || (i_imem_req && i_imem_resp));
            r_d_done <= w_mem_pend && (w_d_done || (i_dmem_req && i_dmem_resp));
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_cycles, r_flush_count, r_load_use_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles   <= '0;
            r_flush_count    <= '0;
            r_load_use_count <= '0;
        end else begin
            if (w_mem_pend && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + PERF_W'(1);
            if (w_flush && r_flush_count != '1) r_flush_count <= r_flush_count + PERF_W'(1);
            if (w_load_use && r_load_use_count != '1) r_load_use_count <= r_load_use_count + PERF_W'(1);
        end
    end

    assign o_stall_cycles   = r_stall_cycles;
    assign o_flush_count    = r_flush_count;
    assign o_load_use_count = r_load_use_count;
`else
    assign o_stall_cycles   = '0;
    assign o_flush_count    = '0;
    assign o_load_use_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors for the hazard sequencer with hand-computed expectations.
module tb_pipeline_hazard_ctrl;
    localparam logic [6:0] STALL = 7'b00000_00;
    localparam logic [6:0] NORM  = 7'b11111_00;
    localparam logic [6:0] LU    = 7'b00111_01;
    localparam logic [6:0] FL    = 7'b11111_11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_resp, dmem_req, dmem_resp;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, mr, br;
    logic        lpc, lifid, lidex, lexmem, lmemwb, bifid, bidex;
    logic [31:0] stall_cycles, flush_count, load_use_count;
    logic [6:0]  ctl;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.PERF_W(32)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_imem_req       (imem_req),
        .i_imem_resp      (imem_resp),
        .i_dmem_req       (dmem_req),
        .i_dmem_resp      (dmem_resp),
        .i_id_rs1         (rs1),
        .i_id_rs2         (rs2),
        .i_id_uses_rs1    (u1),
        .i_id_uses_rs2    (u2),
        .i_ex_rd          (rd),
        .i_ex_mem_read    (mr),
        .i_ex_br_taken    (br),
        .o_load_pc        (lpc),
        .o_load_if_id     (lifid),
        .o_load_id_ex     (lidex),
        .o_load_ex_mem    (lexmem),
        .o_load_mem_wb    (lmemwb),
        .o_bubble_if_id   (bifid),
        .o_bubble_id_ex   (bidex),
        .o_stall_cycles   (stall_cycles),
        .o_flush_count    (flush_count),
        .o_load_use_count (load_use_count)
    );

    assign ctl = {lpc, lifid, lidex, lexmem, lmemwb, bifid, bidex};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] pe(input int v);
`ifdef HAZARD_PERF_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    task automatic idle();
        {imem_req, imem_resp, dmem_req, dmem_resp} = '0;
        {rs1, rs2, rd, u1, u2, mr, br} = '0;
    endtask

    task automatic cyc(input string tag, input logic [6:0] exp);
        #1 chk(tag, 32'(ctl), 32'(exp));
        @(negedge clk);
    endtask

    task automatic perf(input string tag, input int s, input int f, input int l);
        chk({tag, "_stall"}, stall_cycles, pe(s));
        chk({tag, "_flush"}, flush_count, pe(f));
        chk({tag, "_lu"}, load_use_count, pe(l));
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        imem_req = 1'b0;
        @(negedge clk);
        cyc("reset_held", STALL);
        perf("reset", 0, 0, 0);
        rst_n = 1'b1;
        cyc("first_run", NORM);
        // load-use via rs1, then the load has moved on
        rd = 5; mr = 1; rs1 = 5; u1 = 1;
        cyc("lu_rs1", LU);
        mr = 0;
        cyc("lu_after", NORM);
        idle(); rd = 7; mr = 1; rs2 = 7; u2 = 1;
        cyc("lu_rs2", LU);
        u2 = 0; rs1 = 7; u1 = 0;
        cyc("lu_unused_src", NORM);
        idle(); rd = 0; mr = 1; rs1 = 0; u1 = 1;
        cyc("x0_dest", NORM);
        perf("lu", 0, 0, 2);
        // I-miss: req held 4 cycles, resp on the 4th
        idle(); imem_req = 1;
        cyc("imiss_c1", STALL);
        cyc("imiss_c2", STALL);
        cyc("imiss_c3", STALL);
        imem_resp = 1;
        cyc("imiss_c4", NORM);
        perf("imiss", 3, 0, 2);
        // split miss: D responds first, I later
        idle(); imem_req = 1; dmem_req = 1;
        cyc("split_c1", STALL);
        dmem_resp = 1;
        cyc("split_c2", STALL);
        dmem_resp = 0;
        cyc("split_c3", STALL);
        cyc("split_c4", STALL);
        imem_resp = 1;
        cyc("split_c5", NORM);
        idle();
        cyc("split_idle", NORM);
        dmem_req = 1;
        cyc("dflag_cleared", STALL);
        dmem_resp = 1;
        cyc("dmiss_exit", NORM);
        idle(); imem_resp = 1;
        cyc("orphan_resp", NORM);
        imem_resp = 0; imem_req = 1;
        cyc("no_flag_orphan", STALL);
        imem_resp = 1;
        cyc("orphan_exit", NORM);
        perf("split", 9, 0, 2);
        // branch with load-use present: flush only
        idle(); rd = 5; mr = 1; rs1 = 5; u1 = 1; br = 1;
        cyc("br_lu", FL);
        perf("br", 9, 1, 2);
        idle(); imem_req = 1; br = 1;
        cyc("br_in_miss", STALL);
        imem_resp = 1;
        cyc("br_miss_exit", FL);
        idle(); imem_req = 1;
        cyc("lu_miss_wait", STALL);
        imem_resp = 1; rd = 3; mr = 1; rs2 = 3; u2 = 1;
        cyc("lu_miss_exit", LU);
        perf("exit_rules", 11, 2, 3);
        // reset in cycle 2 of a D-miss
        idle(); dmem_req = 1;
        cyc("dmiss_c1", STALL);
        rst_n = 1'b0;
        #1 chk("rst_mid_ctl", 32'(ctl), 32'(STALL));
        perf("rst_mid", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; idle();
        cyc("after_rst", NORM);
        perf("after_rst", 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
